// File: rtl/traffic_lane_pkg.sv
// Shared constants and helpers for one frogger traffic lane.
// Holds the row width, LFSR taps and the car spacing limits.
package traffic_lane_pkg;

   localparam int          ROW_W     = 16;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam logic [2:0]  MIN_GAP   = 3'd2;
   localparam logic [2:0]  MAX_GAP   = 3'd6;

   // Right-shifting Galois step, taps 16,14,13,11
   function automatic logic [15:0] lfsr_next(
      input logic [15:0] s
   );
      return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/traffic_lane_lfsr16.sv
// 16-bit Galois LFSR used as the lane's car source.
// Loads seed on reset and steps only when advance is high.
module lfsr16
   import traffic_lane_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        advance,
   input  logic [15:0] seed,
   output logic [15:0] state
);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= seed;
      end else if (advance) begin
         state <= lfsr_next(state);
      end
   end

endmodule

// File: rtl/traffic_lane.sv
// One lane of cars: tick divider, spaced random spawn, shifter,
// and an edge-detected frog collision pulse.
module traffic_lane
   import traffic_lane_pkg::*;
#(
   parameter int          PERIOD   = 8,
   parameter bit          DIR_LEFT = 1'b1,
   parameter logic [15:0] SEED     = 16'hACE1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             pause,
   input  logic [ROW_W-1:0] frogRow,
   output logic [ROW_W-1:0] cars,
   output logic             hit
);

   localparam logic [15:0] SEED_EFF =
      (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam logic [7:0] LAST = 8'(PERIOD - 1);

   logic [7:0]       div;
   logic [2:0]       gap;
   logic [15:0]      lfsr;
   logic             ovp;
   logic             step;
   logic             cand;
   logic             spawn;
   logic             overlap;
   logic [ROW_W-1:0] cars_next;

   lfsr16 u_lfsr (
      .clk     (clk),
      .reset   (reset),
      .advance (step),
      .seed    (SEED_EFF),
      .state   (lfsr)
   );

   always_comb begin
      step    = tick & ~pause & (div == LAST);
      cand    = lfsr[0] & lfsr[1];
      overlap = |(cars & frogRow);
      spawn   = cand;
      // Spacing rules override the random candidate
      if (gap < MIN_GAP) begin
         spawn = 1'b0;
      end else if (gap == MAX_GAP) begin
         spawn = 1'b1;
      end
      if (DIR_LEFT) begin
         cars_next = {cars[ROW_W-2:0], spawn};
      end else begin
         cars_next = {spawn, cars[ROW_W-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div  <= 8'd0;
         gap  <= MIN_GAP;
         cars <= '0;
         ovp  <= 1'b0;
         hit  <= 1'b0;
      end else begin
         ovp <= overlap;
         hit <= overlap & ~ovp & ~pause;
         if (tick && !pause) begin
            div <= step ? 8'd0 : div + 8'd1;
         end
         if (step) begin
            cars <= cars_next;
            if (spawn) begin
               gap <= 3'd0;
            end else if (gap != 3'd7) begin
               gap <= gap + 3'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_traffic_lane.sv
// Directed bench for traffic_lane: a PERIOD=4 left lane and a
// PERIOD=8 right lane with SEED=0, driven from shared inputs.
module tb_traffic_lane;

   logic        clk = 1'b0;
   logic        reset;
   logic        tick;
   logic        pause;
   logic [15:0] frog_row;
   logic [15:0] cars_a;
   logic [15:0] cars_b;
   logic        hit_a;
   logic        hit_b;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   traffic_lane #(
      .PERIOD   (4),
      .DIR_LEFT (1'b1),
      .SEED     (16'hACE1)
   ) dut_a (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .pause   (pause),
      .frogRow (frog_row),
      .cars    (cars_a),
      .hit     (hit_a)
   );

   traffic_lane #(
      .PERIOD   (8),
      .DIR_LEFT (1'b0),
      .SEED     (16'h0000)
   ) dut_b (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .pause   (pause),
      .frogRow (frog_row),
      .cars    (cars_b),
      .hit     (hit_b)
   );

   typedef struct {
      int          n;
      logic        t;
      logic        p;
      logic [15:0] f;
      logic [15:0] ea;
      logic        ha;
      logic [15:0] eb;
      logic        hb;
   } vec_t;

   vec_t tbl[$];

   task automatic cyc(
      input logic        r,
      input logic        t,
      input logic        p,
      input logic [15:0] f
   );
      reset    = r;
      tick     = t;
      pause    = p;
      frog_row = f;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(
      input string       nm,
      input logic [15:0] act,
      input logic [15:0] exp
   );
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Independent bitwise form of the taps-16,14,13,11 step
   function automatic logic [15:0] mdl_lfsr(
      input logic [15:0] s
   );
      logic [15:0] n;
      for (int i = 0; i < 15; i++) n[i] = s[i+1];
      n[15] = s[0];
      n[13] = s[14] ^ s[0];
      n[12] = s[13] ^ s[0];
      n[10] = s[11] ^ s[0];
      return n;
   endfunction

   initial begin
      logic [15:0] ml;
      logic [15:0] mc;
      logic [2:0]  mg;
      logic        sp;
      int          zeros;

      tbl.push_back('{1,  1'b0, 1'b0, 16'h0000,
                      16'h0000, 1'b0, 16'h0000, 1'b0});
      tbl.push_back('{19, 1'b1, 1'b0, 16'h0000,
                      16'h0000, 1'b0, 16'h0000, 1'b0});
      tbl.push_back('{3,  1'b0, 1'b1, 16'h0000,
                      16'h0000, 1'b0, 16'h0000, 1'b0});
      tbl.push_back('{2,  1'b1, 1'b1, 16'h0000,
                      16'h0000, 1'b0, 16'h0000, 1'b0});
      tbl.push_back('{1,  1'b1, 1'b0, 16'h0000,
                      16'h0001, 1'b0, 16'h0000, 1'b0});
      tbl.push_back('{4,  1'b1, 1'b0, 16'h0000,
                      16'h0002, 1'b0, 16'h0000, 1'b0});
      tbl.push_back('{3,  1'b1, 1'b0, 16'h0000,
                      16'h0002, 1'b0, 16'h0000, 1'b0});
      tbl.push_back('{1,  1'b1, 1'b0, 16'h0002,
                      16'h0004, 1'b1, 16'h0000, 1'b0});
      tbl.push_back('{1,  1'b0, 1'b0, 16'h0002,
                      16'h0004, 1'b0, 16'h0000, 1'b0});
      tbl.push_back('{1,  1'b0, 1'b0, 16'h0004,
                      16'h0004, 1'b1, 16'h0000, 1'b0});
      tbl.push_back('{3,  1'b0, 1'b0, 16'h0004,
                      16'h0004, 1'b0, 16'h0000, 1'b0});
      tbl.push_back('{1,  1'b0, 1'b1, 16'h0000,
                      16'h0004, 1'b0, 16'h0000, 1'b0});
      tbl.push_back('{1,  1'b0, 1'b1, 16'h0004,
                      16'h0004, 1'b0, 16'h0000, 1'b0});
      tbl.push_back('{1,  1'b0, 1'b0, 16'h0004,
                      16'h0004, 1'b0, 16'h0000, 1'b0});
      tbl.push_back('{1,  1'b0, 1'b0, 16'h0000,
                      16'h0004, 1'b0, 16'h0000, 1'b0});
      tbl.push_back('{1,  1'b0, 1'b0, 16'h0004,
                      16'h0004, 1'b1, 16'h0000, 1'b0});
      tbl.push_back('{1,  1'b0, 1'b0, 16'h0000,
                      16'h0004, 1'b0, 16'h0000, 1'b0});
      tbl.push_back('{12, 1'b1, 1'b0, 16'h0000,
                      16'h0020, 1'b0, 16'h8000, 1'b0});
      tbl.push_back('{1,  1'b0, 1'b0, 16'hFFFF,
                      16'h0020, 1'b1, 16'h8000, 1'b1});
      tbl.push_back('{5,  1'b0, 1'b0, 16'hFFFF,
                      16'h0020, 1'b0, 16'h8000, 1'b0});

      cyc(1'b1, 1'b0, 1'b0, 16'h0000);
      cyc(1'b1, 1'b0, 1'b0, 16'h0000);
      chk("rst_cars_a", cars_a, 16'h0000);
      chk("rst_hit_a", 16'(hit_a), 16'h0000);
      chk("rst_cars_b", cars_b, 16'h0000);
      chk("rst_lfsr_b", dut_b.u_lfsr.state, 16'h0001);

      foreach (tbl[i]) begin
         repeat (tbl[i].n) cyc(1'b0, tbl[i].t, tbl[i].p, tbl[i].f);
         chk($sformatf("v%0d_cars_a", i), cars_a, tbl[i].ea);
         chk($sformatf("v%0d_hit_a", i), 16'(hit_a), 16'(tbl[i].ha));
         chk($sformatf("v%0d_cars_b", i), cars_b, tbl[i].eb);
         chk($sformatf("v%0d_hit_b", i), 16'(hit_b), 16'(tbl[i].hb));
      end

      // Reset mid-traffic wins over tick and pause
      cyc(1'b1, 1'b1, 1'b1, 16'hFFFF);
      cyc(1'b1, 1'b1, 1'b1, 16'hFFFF);
      chk("mid_rst_cars_a", cars_a, 16'h0000);
      chk("mid_rst_cars_b", cars_b, 16'h0000);
      chk("mid_rst_hit_a", 16'(hit_a), 16'h0000);
      chk("mid_rst_hit_b", 16'(hit_b), 16'h0000);
      chk("mid_rst_lfsr_a", dut_a.u_lfsr.state, 16'hACE1);
      chk("mid_rst_lfsr_b", dut_b.u_lfsr.state, 16'h0001);

      ml    = 16'hACE1;
      mc    = 16'h0000;
      mg    = 3'd2;
      zeros = 2;
      for (int k = 1; k <= 200; k++) begin
         for (int c = 0; c < 4; c++) begin
            cyc(1'b0, 1'b1, 1'b0, 16'h0000);
            if (k == 1 && c == 2)
               chk("lfsr_a_pre", dut_a.u_lfsr.state, 16'hACE1);
            if (k == 2 && c == 2)
               chk("lfsr_b_pre", dut_b.u_lfsr.state, 16'h0001);
         end
         if (k == 1)
            chk("lfsr_a_first", dut_a.u_lfsr.state, 16'hE270);
         if (k == 2)
            chk("lfsr_b_first", dut_b.u_lfsr.state, 16'hB400);
         if (k == 9)
            chk("b_no_spawn", cars_b, 16'h0000);
         if (k == 10)
            chk("b_spawn", cars_b, 16'h8000);
         if (mg < 3'd2) sp = 1'b0;
         else if (mg == 3'd6) sp = 1'b1;
         else sp = ml[0] & ml[1];
         mc = {mc[14:0], sp};
         mg = sp ? 3'd0 : mg + 3'd1;
         ml = mdl_lfsr(ml);
         chk($sformatf("step%0d_cars", k), cars_a, mc);
         if (cars_a[0]) begin
            chk($sformatf("step%0d_mingap", k),
                16'(zeros >= 2), 16'h0001);
            zeros = 0;
         end else begin
            zeros++;
            chk($sformatf("step%0d_maxgap", k),
                16'(zeros < 7), 16'h0001);
         end
      end

      // Pause onto an overlap, then release
      for (int i = 0; i < 20; i++) begin
         cyc(1'b0, 1'b1, 1'b1, 16'hFFFF);
         chk("pause_hit", 16'(hit_a), 16'h0000);
      end
      chk("pause_cars", cars_a, mc);
      cyc(1'b0, 1'b0, 1'b0, 16'hFFFF);
      chk("release_hit", 16'(hit_a), 16'h0000);
      cyc(1'b0, 1'b0, 1'b0, 16'h0000);
      chk("drop_hit", 16'(hit_a), 16'h0000);
      cyc(1'b0, 1'b0, 1'b0, 16'hFFFF);
      chk("return_hit", 16'(hit_a), 16'h0001);
      cyc(1'b0, 1'b0, 1'b0, 16'hFFFF);
      chk("return_hold", 16'(hit_a), 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
